dnn_scheduler: RTL and testbench
================================

# dnn_scheduler

Sequencing controller for the DNN MAC datapath, sitting between the CPU control/decode stage and the weight/activation memory plus MAC accumulator. Accepts custom DNN instructions (opcode bits [1:0] = 01 or 10), stalls the CPU, streams `len` operands from memory into the MAC, and writes the (optionally ReLU-clamped) accumulator back to the register file. One job in flight at a time.

## Interface
- `ADDR_W`, 10, operand memory address width
- `DATA_W`, 32, accumulator / writeback width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `inst_valid` in 1: `instruction_to_dnn` is valid this cycle
- `instruction_to_dnn` in 32: instruction from control; [1:0] op, [11:7] rd, [19:12] len, [31:20] base
- `mac_acc` in DATA_W: MAC accumulator value
- `cpu_stall` out 1: hold PC/instruction
- `DnnSel` out 2: mode of last accepted job (1 = dense, 2 = dense+ReLU)
- `busy` out 1: FSM not in IDLE
- `mem_rd` out 1, `mem_addr` out ADDR_W: operand read request (1-cycle read latency)
- `mac_clr` out 1: clear accumulator
- `mac_en` out 1: accumulate current memory read data
- `wb_en` out 1, `wb_rd` out 5, `wb_data` out DATA_W: register-file writeback
- `abort` in 1: only when `DNN_SCHED_ABORT_EN` defined

## Operation
- States: IDLE, LOAD, FETCH, DRAIN, WB.
- IDLE: accept when `inst_valid` & op ∈ {01,10}; latch rd, len, base, mode; `DnnSel` <= op; -> LOAD. Op 00/11 ignored.
- LOAD: `mac_clr`=1 one cycle; cnt <= 0; -> FETCH if len≠0, else -> WB.
- FETCH: `mem_rd`=1, `mem_addr` = (base + cnt) mod 2^ADDR_W; cnt++; after issuing cnt = len-1 -> DRAIN.
- `mac_en` is `mem_rd` delayed one cycle (asserted FETCH cycles 2..len and in DRAIN).
- DRAIN: `mac_en`=1 for last operand; -> WB.
- WB: `wb_en`=1, `wb_rd` = latched rd; `wb_data` = `mac_acc`, except mode 2 with `mac_acc[DATA_W-1]`=1 -> 0; -> IDLE.
- rd = 0: job executes, `wb_en` still pulses (register file discards x0).
- `cpu_stall` = (IDLE & accept) | LOAD | FETCH | DRAIN; low in WB so CPU advances at end of WB cycle.
- `inst_valid` outside IDLE is ignored (no queueing).
- `busy` = state ≠ IDLE.

## Timing
- Reset (async, immediate): state IDLE; all outputs 0, including `DnnSel`, `mem_addr`, `wb_data`, cnt.
- Reset mid-job: job discarded, no writeback.
- Accept at cycle T: LOAD T+1, FETCH T+2..T+1+len, DRAIN T+2+len, WB T+3+len, IDLE T+4+len.
- len = 0: LOAD T+1, WB T+2, `wb_data` = cleared acc (0).
- Total stall cycles = len+3 (len≥1), 2 (len=0).
- cnt is 8 bits; max len 255; address wrap past 2^ADDR_W-1 to 0 is legal.
- Back-to-back jobs: new job accepted in the first IDLE cycle after WB.

## Configuration
- `DNN_SCHED_ABORT_EN` defined: `abort` port present; `abort`=1 in LOAD/FETCH/DRAIN -> IDLE next cycle, `mem_rd`/`mac_en` drop, no `wb_en`, `cpu_stall` drops in that abort cycle; `abort` in IDLE/WB ignored (WB completes).
- Undefined: no `abort` port; jobs always run to WB.

## Test plan
- Mode 1, base=0x010, len=4, rd=5, mem[0x10..0x13] = 1,2,3,4 -> `mem_addr` 0x10..0x13 T+2..T+5, `wb_en` at T+7, `wb_rd`=5, `wb_data`=10, stall 7 cycles.
- Mode 2, len=2, operands produce acc = 0xFFFF_FFF6 (-10) -> `wb_data`=0, `DnnSel`=2; same in mode 1 -> `wb_data`=0xFFFF_FFF6.
- len=0, rd=3 -> `mac_clr` at T+1, `wb_en` at T+2, `wb_data`=0, no `mem_rd`.
- base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- `rst_n` low during FETCH cycle 3 of len=8 -> all outputs 0 same cycle, no `wb_en`; next valid instruction accepted normally; op=11 instruction never stalls.
- With `DNN_SCHED_ABORT_EN`: `abort` at FETCH cycle 2 -> IDLE next cycle, no writeback, following job completes with correct sum.

Source files
------------

// File: rtl/dnn_scheduler.sv
// Sequencing controller for DNN MAC jobs: stalls the CPU, streams operands into the MAC, writes back the result.
// Optional abort input is enabled by defining DNN_SCHED_ABORT_EN.
module dnn_scheduler #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [31:0]       instruction_to_dnn,
  input  logic [DATA_W-1:0] mac_acc,
  output logic              cpu_stall,
  output logic [1:0]        DnnSel,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
`ifdef DNN_SCHED_ABORT_EN
  ,
  input  logic              abort
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_DRAIN, S_WB} state_t;

  state_t              r_state;
  logic [4:0]          r_rd;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic                r_relu;
  logic [1:0]          r_dnn_sel;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mac_clr;
  logic                r_mac_en;
  logic                r_wb_en;

  logic                w_op_ok;
  logic                w_accept;
  logic                w_running;
  logic                w_abort;
  logic                w_unused_bits;

  // Negative accumulator values clamp to zero in dense+ReLU mode.
  function automatic logic [DATA_W-1:0] relu_sel(input logic relu, input logic [DATA_W-1:0] acc);
    relu_sel = (relu && acc[DATA_W-1]) ? {DATA_W{1'b0}} : acc;
  endfunction

  assign w_op_ok       = (instruction_to_dnn[1:0] == 2'b01) || (instruction_to_dnn[1:0] == 2'b10);
  assign w_accept      = rst_n && (r_state == S_IDLE) && inst_valid && w_op_ok;
  assign w_running     = (r_state == S_LOAD) || (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_unused_bits = ^instruction_to_dnn[6:2];

`ifdef DNN_SCHED_ABORT_EN
  assign w_abort = abort && w_running;
`else
  assign w_abort = 1'b0;
`endif

  assign cpu_stall = w_accept || (w_running && !w_abort);
  assign busy      = (r_state != S_IDLE);
  assign DnnSel    = r_dnn_sel;
  assign mem_rd    = r_mem_rd && !w_abort;
  assign mem_addr  = r_mem_addr;
  assign mac_clr   = r_mac_clr && !w_abort;
  assign mac_en    = r_mac_en && !w_abort;
  assign wb_en     = r_wb_en;
  assign wb_rd     = r_wb_en ? r_rd : 5'd0;
  // The accumulator only holds the final sum during the WB cycle itself, so the result is taken live.
  assign wb_data   = r_wb_en ? relu_sel(r_relu, mac_acc) : {DATA_W{1'b0}};

  // Job sequencing FSM with registered datapath controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd       <= 5'd0;
      r_len      <= 8'd0;
      r_cnt      <= 8'd0;
      r_base     <= {ADDR_W{1'b0}};
      r_relu     <= 1'b0;
      r_dnn_sel  <= 2'd0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_mac_clr  <= 1'b0;
      r_mac_en   <= 1'b0;
      r_wb_en    <= 1'b0;
    end else begin
      r_mac_en <= r_mem_rd && !w_abort;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd      <= instruction_to_dnn[11:7];
            r_len     <= instruction_to_dnn[19:12];
            r_base    <= ADDR_W'(instruction_to_dnn[31:20]);
            r_relu    <= (instruction_to_dnn[1:0] == 2'b10);
            r_dnn_sel <= instruction_to_dnn[1:0];
            r_mac_clr <= 1'b1;
            r_state   <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_mac_clr <= 1'b0;
          r_cnt     <= 8'd0;
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (r_len != 8'd0) begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_base;
            r_state    <= S_FETCH;
          end else begin
            r_wb_en <= 1'b1;
            r_state <= S_WB;
          end
        end
        S_FETCH: begin
          if (w_abort) begin
            r_mem_rd   <= 1'b0;
            r_mem_addr <= {ADDR_W{1'b0}};
            r_state    <= S_IDLE;
          end else if (r_cnt == (r_len - 8'd1)) begin
            r_mem_rd   <= 1'b0;
            r_mem_addr <= {ADDR_W{1'b0}};
            r_state    <= S_DRAIN;
          end else begin
            r_cnt      <= r_cnt + 8'd1;
            r_mem_addr <= r_mem_addr + ADDR_W'(1'b1);
          end
        end
        S_DRAIN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_wb_en <= 1'b1;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_wb_en <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_rd  <= 1'b0;
          r_mac_clr <= 1'b0;
          r_wb_en   <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_scheduler.sv
// Directed bench for dnn_scheduler: operand memory + MAC accumulator model, table of jobs, reset/illegal-op/abort sequences.
module tb_dnn_scheduler;
  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] instruction_to_dnn;
  logic [31:0] mac_acc;
  logic        cpu_stall;
  logic [1:0]  DnnSel;
  logic        busy;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic        mac_clr;
  logic        mac_en;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef DNN_SCHED_ABORT_EN
  logic        abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] rdata = 32'd0;
  logic [31:0] acc   = 32'd0;

  dnn_scheduler #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid),
    .instruction_to_dnn(instruction_to_dnn), .mac_acc(mac_acc),
    .cpu_stall(cpu_stall), .DnnSel(DnnSel), .busy(busy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef DNN_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memory with one-cycle read latency feeding a clear/accumulate MAC.
  always @(posedge clk) begin
    if (mem_rd) rdata <= mem[mem_addr];
    if (mac_clr) acc <= 32'd0;
    else if (mac_en) acc <= acc + rdata;
  end
  assign mac_acc = acc;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [7:0]  len;
    logic [11:0] base;
    logic [31:0] exp_data;
    int          exp_wb;
    int          exp_stall;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [1:0] op, input logic [4:0] rd,
                                           input logic [7:0] len, input logic [11:0] base);
    mk_instr = {base, len, rd, 5'b00000, op};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_sel"},   {30'd0, DnnSel}, 32'd0);
    check({tag, "_memrd"}, {31'd0, mem_rd}, 32'd0);
    check({tag, "_addr"},  {22'd0, mem_addr}, 32'd0);
    check({tag, "_clr"},   {31'd0, mac_clr}, 32'd0);
    check({tag, "_en"},    {31'd0, mac_en}, 32'd0);
    check({tag, "_wb"},    {31'd0, wb_en}, 32'd0);
    check({tag, "_wbd"},   wb_data, 32'd0);
  endtask

  task automatic run_job(input vec_t v, input int idx);
    int stalls, clr_k, nrd, wb_k, wb_cnt, done_k, bad_rd;
    logic [9:0] exp_addr;
    string tag;
    tag = $sformatf("job%0d", idx);
    stalls = 0; clr_k = 0; nrd = 0; wb_k = 0; wb_cnt = 0; done_k = 0; bad_rd = 0;
    @(negedge clk);
    instruction_to_dnn = mk_instr(v.op, v.rd, v.len, v.base);
    inst_valid = 1'b1;
    #1;
    check({tag, "_accept_stall"}, {31'd0, cpu_stall}, 32'd1);
    if (cpu_stall) stalls++;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      inst_valid = (k == 2);
      #1;
      if (cpu_stall) stalls++;
      if (mac_clr && clr_k == 0) clr_k = k;
      if (mem_rd) begin
        exp_addr = v.base[9:0] + 10'(nrd);
        if (mem_addr !== exp_addr || k != nrd + 2) bad_rd++;
        nrd++;
      end
      if (wb_en) begin
        wb_k = k;
        wb_cnt++;
        check({tag, "_wb_rd"},   {27'd0, wb_rd}, {27'd0, v.rd});
        check({tag, "_wb_data"}, wb_data, v.exp_data);
        check({tag, "_dnnsel"},  {30'd0, DnnSel}, {30'd0, v.op});
      end
      if (!busy) begin
        done_k = k;
        break;
      end
    end
    inst_valid = 1'b0;
    check({tag, "_clr_cycle"},  clr_k, 32'd1);
    check({tag, "_rd_count"},   nrd, {24'd0, v.len});
    check({tag, "_rd_addr"},    bad_rd, 32'd0);
    check({tag, "_wb_cycle"},   wb_k, v.exp_wb);
    check({tag, "_wb_count"},   wb_cnt, 32'd1);
    check({tag, "_stall_cyc"},  stalls, v.exp_stall);
    check({tag, "_idle_cycle"}, done_k, v.exp_wb + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wb_seen;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    mem[10'h010] = 32'd1; mem[10'h011] = 32'd2; mem[10'h012] = 32'd3; mem[10'h013] = 32'd4;
    mem[10'h020] = 32'hFFFF_FFF0; mem[10'h021] = 32'd6;

    vecs[0] = '{2'b01, 5'd5,  8'd4, 12'h010, 32'd10,        7, 7};
    vecs[1] = '{2'b10, 5'd7,  8'd2, 12'h020, 32'd0,         5, 5};
    vecs[2] = '{2'b01, 5'd7,  8'd2, 12'h020, 32'hFFFF_FFF6, 5, 5};
    vecs[3] = '{2'b01, 5'd3,  8'd0, 12'h055, 32'd0,         2, 2};
    vecs[4] = '{2'b01, 5'd9,  8'd4, 12'h3FE, 32'h0000_07FE, 7, 7};
    vecs[5] = '{2'b10, 5'd0,  8'd3, 12'h100, 32'h0000_0303, 6, 6};
    vecs[6] = '{2'b10, 5'd31, 8'd1, 12'h200, 32'h0000_0200, 4, 4};

    rst_n = 1'b0;
    inst_valid = 1'b0;
    instruction_to_dnn = 32'd0;
`ifdef DNN_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_job(vecs[i], i);

    // Reset during the third FETCH cycle of a len=8 job.
    @(negedge clk);
    instruction_to_dnn = mk_instr(2'b01, 5'd4, 8'd8, 12'h040);
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midjob_addr", {22'd0, mem_addr}, 32'h042);
    rst_n = 1'b0;
    #1;
    check_all_zero("midjob_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wb_seen = 0;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (wb_en || busy) wb_seen++;
    end
    check("post_rst_no_wb", wb_seen, 32'd0);

    // Illegal opcodes are ignored and never stall.
    @(negedge clk);
    instruction_to_dnn = mk_instr(2'b11, 5'd1, 8'd2, 12'h010);
    inst_valid = 1'b1;
    #1;
    check("op11_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    instruction_to_dnn = mk_instr(2'b00, 5'd1, 8'd2, 12'h010);
    #1;
    check("op11_busy", {31'd0, busy}, 32'd0);
    check("op00_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    inst_valid = 1'b0;
    #1;
    check("op00_busy", {31'd0, busy}, 32'd0);

    run_job(vecs[0], 10);

`ifdef DNN_SCHED_ABORT_EN
    // Abort in the second FETCH cycle, then a normal job.
    @(negedge clk);
    instruction_to_dnn = mk_instr(2'b01, 5'd6, 8'd8, 12'h010);
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_memrd", {31'd0, mem_rd}, 32'd0);
    check("abort_macen", {31'd0, mac_en}, 32'd0);
    wb_seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (wb_en) wb_seen++;
    end
    check("abort_no_wb", wb_seen, 32'd0);
    run_job(vecs[0], 11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
